// File: rtl/pmem_loader_pkg.sv
// Shared constants and types for the boot-time program loader.
package pmem_loader_pkg;

  localparam int unsigned ILen         = 32;
  localparam int unsigned AddrWidth    = 16;
  localparam int unsigned IdxWidth     = AddrWidth - 2;
  localparam int unsigned MaxWords     = 2 ** IdxWidth;
  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned HeaderBytes  = 2;

  typedef enum logic [2:0] {
    LOAD_LEN_LO,
    LOAD_LEN_HI,
    LOAD_DATA,
    LOAD_CSUM,
    LOAD_DONE,
    LOAD_ERROR
  } load_state_e;

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// master: byte source / memory side; slave: the loader itself.
interface pmem_loader_if;
  import pmem_loader_pkg::*;

  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 pmem_we;
  logic [AddrWidth-1:0] pmem_waddr;
  logic [ILen-1:0]      pmem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, pmem_we, pmem_waddr, pmem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, pmem_we, pmem_waddr, pmem_wdata
  );

endinterface

// File: rtl/pmem_word_packer.sv
// Collects bytes into little-endian 32-bit words. word_valid_o is raised
// combinationally together with the fourth byte of each word.
module pmem_word_packer
  import pmem_loader_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_i,
  output logic            word_valid_o,
  output logic [ILen-1:0] word_o
);

  localparam logic [1:0] LastByte = 2'(BytesPerWord - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  // Next byte position and partial-word buffer update.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: ;
      endcase
    end
  end

  // Byte counter and buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == LastByte);
  assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/pmem_loader.sv
// Boot-time program loader: parses a length-prefixed byte stream, writes
// 32-bit words to program memory from address 0 and holds the core in reset
// until the image is complete. Define PMEM_LOADER_CHECKSUM_EN to require a
// trailing XOR checksum byte before the core is released.
module pmem_loader
  import pmem_loader_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  pmem_loader_if.slave bus,
  output logic         core_rst_no,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

`ifdef PMEM_LOADER_CHECKSUM_EN
  localparam load_state_e AfterData = LOAD_CSUM;
`else
  localparam load_state_e AfterData = LOAD_DONE;
`endif

  load_state_e          state_q, state_d;
  logic                 rx_ready, accept, restart, idle;
  logic                 byte_valid, word_valid, last_word;
  logic [ILen-1:0]      word;
  logic [15:0]          n_hdr;
  logic [7:0]           len_lo_q;
  logic [IdxWidth-1:0]  len_m1_q, idx_q;
  logic                 we_q, rst_n_q, done_q, err_q;
  logic [AddrWidth-1:0] waddr_q;
  logic [ILen-1:0]      wdata_q;
`ifdef PMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  assign idle       = (state_q == LOAD_DONE) || (state_q == LOAD_ERROR);
  assign rx_ready   = !idle;
  assign accept     = bus.rx_valid && rx_ready;
  assign restart    = start_i && idle;
  assign byte_valid = accept && (state_q == LOAD_DATA);
  assign n_hdr      = {bus.rx_data, len_lo_q};
  assign last_word  = (idx_q == len_m1_q);

  pmem_word_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (restart),
    .byte_valid_i (byte_valid),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state logic of the frame parser.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_LEN_LO: if (accept) state_d = LOAD_LEN_HI;
      LOAD_LEN_HI: begin
        if (accept) begin
          if ({1'b0, n_hdr} > 17'(MaxWords)) state_d = LOAD_ERROR;
          else if (n_hdr == '0)              state_d = AfterData;
          else                               state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: if (word_valid && last_word) state_d = AfterData;
`ifdef PMEM_LOADER_CHECKSUM_EN
      LOAD_CSUM: begin
        if (accept) state_d = (bus.rx_data == csum_q) ? LOAD_DONE : LOAD_ERROR;
      end
`endif
      LOAD_DONE, LOAD_ERROR: if (start_i) state_d = LOAD_LEN_LO;
      default: state_d = LOAD_LEN_LO;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LOAD_LEN_LO;
    else         state_q <= state_d;
  end

  // Captured length and write index; the index stops at the last word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_lo_q <= '0;
      len_m1_q <= '0;
      idx_q    <= '0;
    end else begin
      if (state_q == LOAD_LEN_LO && accept) len_lo_q <= bus.rx_data;
      if (state_q == LOAD_LEN_HI && accept) len_m1_q <= IdxWidth'(n_hdr - 16'd1);
      if (restart)                         idx_q <= '0;
      else if (word_valid && !last_word)   idx_q <= idx_q + 1'b1;
    end
  end

  // Program-memory write port; address and data hold between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= word_valid;
      if (word_valid) begin
        waddr_q <= {idx_q, 2'b00};
        wdata_q <= word;
      end
    end
  end

  // Status outputs follow the state being entered so they switch on that edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_n_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rst_n_q <= (state_d == LOAD_DONE);
      done_q  <= (state_d == LOAD_DONE);
      err_q   <= (state_d == LOAD_ERROR);
    end
  end

`ifdef PMEM_LOADER_CHECKSUM_EN
  // Running XOR over data bytes only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         csum_q <= '0;
    else if (restart)    csum_q <= '0;
    else if (byte_valid) csum_q <= csum_q ^ bus.rx_data;
  end
`endif

  assign bus.rx_ready   = rx_ready;
  assign bus.pmem_we    = we_q;
  assign bus.pmem_waddr = waddr_q;
  assign bus.pmem_wdata = wdata_q;
  assign core_rst_no    = rst_n_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign busy_o         = !idle;

endmodule
